// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid and sync flush; optional stall counter via PIPE_STALL_CNT_EN.
// Latency: 1 cycle from acceptance to out_data/out_valid; one transfer per cycle when out_ready is held high.
// Backpressure: in_ready is a flop (next_state != FULL), so out_ready never reaches in_ready combinationally.
module pipe_reg_skid #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             acc, pop;

    assign acc       = in_valid & in_ready_q;
    assign pop       = (state_q != EMPTY) & out_ready;
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = in_data;
                    end else if (acc) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the state
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= RST_VAL;
            skid_q     <= RST_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating; deliberately untouched by flush so stall history survives pipeline redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid: directed scenarios plus randomized traffic against a queue-based model.
module tb_pipe_reg_skid;

    localparam logic [7:0] RST = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;

    int checks;
    int errors;

    logic [7:0] mq[$];
    logic [7:0] m_shown;
    logic       m_rdy;
    logic [3:0] m_stall;

    pipe_reg_skid #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        m_shown = RST;
        m_rdy   = 1'b1;
        m_stall = 4'd0;
    endfunction

    // Drive one cycle, advance the model across the edge, return at the following negedge.
    task automatic tick(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
        logic acc;
        logic pop;
        flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        acc = iv && m_rdy;
        pop = (mq.size() != 0) && ordy;
`ifdef PIPE_STALL_CNT_EN
        if ((mq.size() != 0) && !ordy && (m_stall != 4'hF)) m_stall = m_stall + 4'd1;
`endif
        if (fl) begin
            mq.delete();
            m_shown = RST;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            if (mq.size() != 0) m_shown = mq[0];
        end
        m_rdy = (mq.size() < 2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (out_data !== RST) begin errors++; $display("FAIL reset_data got %h exp %h", out_data, RST); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 4; k++) begin
            tick(0, 1, 8'(k), 1);
            checks++; if (out_data !== 8'(k) || out_valid !== 1'b1) begin
                errors++; $display("FAIL stream_data got %h/%b exp %h/1", out_data, out_valid, 8'(k)); end
            checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_occ got occ=%0d rdy=%b exp occ=1 rdy=1", occupancy, in_ready); end
        end
        tick(0, 0, 8'h00, 1);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 8'd4) begin
            errors++; $display("FAIL stream_drain got v=%b occ=%0d d=%h exp v=0 occ=0 d=04", out_valid, occupancy, out_data); end
    endtask

    task automatic test_backpressure();
        tick(0, 1, 8'd10, 0);
        checks++; if (out_data !== 8'd10 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first got d=%h occ=%0d rdy=%b exp 0a/1/1", out_data, occupancy, in_ready); end
        tick(0, 1, 8'd11, 0);
        checks++; if (out_data !== 8'd10 || occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got d=%h occ=%0d rdy=%b exp 0a/2/0", out_data, occupancy, in_ready); end
        tick(0, 1, 8'd12, 0);
        checks++; if (out_data !== 8'd10 || occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold got d=%h occ=%0d rdy=%b exp 0a/2/0", out_data, occupancy, in_ready); end
        tick(0, 1, 8'd12, 1);
        checks++; if (out_data !== 8'd11 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_skid got d=%h occ=%0d rdy=%b exp 0b/1/1", out_data, occupancy, in_ready); end
        tick(0, 1, 8'd12, 1);
        checks++; if (out_data !== 8'd12 || occupancy !== 2'd1) begin
            errors++; $display("FAIL bp_last got d=%h occ=%0d exp 0c/1", out_data, occupancy); end
        tick(0, 0, 8'd0, 1);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL bp_drain got v=%b occ=%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        tick(0, 1, 8'd20, 0);
        tick(0, 1, 8'd21, 0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill got occ=%0d exp 2", occupancy); end
        tick(1, 1, 8'd22, 1);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RST || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got v=%b occ=%0d d=%h rdy=%b exp 0/0/a5/1", out_valid, occupancy, out_data, in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 8'd0, 1);
            checks++; if (out_valid !== 1'b0 || out_data !== RST) begin
                errors++; $display("FAIL flush_leak got v=%b d=%h exp 0/a5", out_valid, out_data); end
        end
    endtask

    task automatic test_async_reset();
        tick(0, 1, 8'd30, 0);
        tick(0, 1, 8'd31, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RST || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL arst_vals got v=%b occ=%0d d=%h rdy=%b st=%0d exp 0/0/a5/1/0",
                               out_valid, occupancy, out_data, in_ready, stall_cnt); end
        model_reset();
        #1 rst_n = 1'b1;
        tick(0, 1, 8'd7, 1);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd7 || occupancy !== 2'd1) begin
            errors++; $display("FAIL arst_first got v=%b d=%h occ=%0d exp 1/07/1", out_valid, out_data, occupancy); end
        tick(0, 0, 8'd0, 1);
    endtask

    task automatic test_stall_cnt();
        logic [3:0] exp_st;
        tick(0, 1, 8'd40, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 8'd0, 0);
`ifdef PIPE_STALL_CNT_EN
        exp_st = 4'hF;
`else
        exp_st = 4'h0;
`endif
        checks++; if (stall_cnt !== exp_st || out_data !== 8'd40) begin
            errors++; $display("FAIL stall_sat got st=%0d d=%h exp %0d/28", stall_cnt, out_data, exp_st); end
        tick(1, 0, 8'd0, 0);
        checks++; if (stall_cnt !== exp_st) begin
            errors++; $display("FAIL stall_flush got %0d exp %0d", stall_cnt, exp_st); end
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 9) < 6));
            exp_d = (mq.size() != 0) ? mq[0] : m_shown;
            checks++; if (out_valid !== (mq.size() != 0) || out_data !== exp_d) begin
                errors++; $display("FAIL rand_out cyc %0d got v=%b d=%h exp v=%b d=%h", i, out_valid, out_data, (mq.size() != 0), exp_d); end
            checks++; if (occupancy !== 2'(mq.size()) || in_ready !== m_rdy) begin
                errors++; $display("FAIL rand_ctl cyc %0d got occ=%0d rdy=%b exp occ=%0d rdy=%b", i, occupancy, in_ready, mq.size(), m_rdy); end
            checks++; if (stall_cnt !== m_stall) begin
                errors++; $display("FAIL rand_stall cyc %0d got %0d exp %0d", i, stall_cnt, m_stall); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_stall_cnt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised pipeline-stage register. Generalises the single-bit enabled/preset flop to a WIDTH-bit stage with a programmable reset value.
- Adds a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Sits between processor pipeline stages (fetch→decode, decode→execute). Gives full throughput under backpressure, and in_ready is a registered output with no combinational path from out_ready.

Parameters:
- WIDTH, 16, payload width in bits (≥1).
- RST_VAL, {WIDTH{1'b0}}, value loaded into the main and skid data registers on reset and on flush (the generalised preset).
- CNT_W, 16, width of the stall counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload; equals main register.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  backpressure cycle count (optional feature).

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - state=EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - Main and skid registers load RST_VAL, so out_data=RST_VAL.
  - stall_cnt=0.
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- States (occupancy is the state encoding): EMPTY(0), ONE(1), FULL(2).
- Transitions on the clk edge when flush=0:
  - EMPTY, acc: main<=in_data; go to ONE.
  - ONE, acc & pop: main<=in_data; stay in ONE.
  - ONE, acc & !pop: skid<=in_data; go to FULL.
  - ONE, !acc & pop: go to EMPTY; main keeps its value.
  - FULL, pop: main<=skid; go to ONE.
  - FULL, !pop: hold.
  - acc cannot occur in FULL, because in_ready=0 there.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready is registered as (next_state != FULL). It deasserts in the cycle after the skid is written and reasserts in the cycle after FULL is left.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (one cycle).
- Throughput: one transfer per cycle when out_ready is held at 1.
- Ordering is strictly FIFO. While out_valid=1 & out_ready=0, out_data stays stable.
- Flush (synchronous; priority over all transitions, below rst_n):
  - Next state is EMPTY; out_valid=0, in_ready=1, occupancy=0.
  - Main and skid registers load RST_VAL.
  - Any acc or pop in the flush cycle is discarded, and the flushed entries are never presented downstream.
- Asynchronous reset mid-transfer: all state is lost immediately and the reset values apply. Upstream data is not acknowledged.
- No combinational path from out_ready to in_ready. out_data is driven only by a register.

Optional Feature:
Macro PIPE_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle where out_valid=1 & out_ready=0. It saturates at all-ones (no wrap). It is cleared only by rst_n; flush does not clear it.
- Undefined: stall_cnt is driven constant 0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
1. Reset with WIDTH=8, RST_VAL=8'hA5 → out_data=8'hA5, out_valid=0, in_ready=1, occupancy=0, without waiting for a clock edge.
2. Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 → out_data shows 1,2,3,4 one cycle later, back-to-back. occupancy stays 1 and in_ready stays 1.
3. Backpressure: stream 10,11,12 with out_ready=0 from the cycle 10 appears → 10 held on out_data; 11 goes to the skid; occupancy=2. in_ready=0 the next cycle, so 12 is held upstream. Raise out_ready → output order is 10,11,12, and in_ready=1 one cycle after FULL is left.
4. Flush while FULL (entries 20,21), with in_valid=1 and data 22 in the same cycle → next cycle out_valid=0, occupancy=0, out_data=RST_VAL, in_ready=1. 20, 21 and 22 never appear on the output.
5. rst_n pulled low mid-stream between clock edges → outputs take their reset values immediately. After release, the first new input 7 appears one cycle after it is accepted.
6. With PIPE_STALL_CNT_EN and CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reads 15 and stays there. A subsequent flush leaves it at 15. Without the macro, stall_cnt=0 throughout.
